// File: rtl/regs_scoreboard.sv
// Decode-stage register scoreboard: tracks non-forwardable in-flight GPR/llbit writes,
// stalls the ID->EX handshake on hazards and counts stall cycles.
module regs_scoreboard #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_re1_i,
    input  logic [4:0]  id_raddr1_i,
    input  logic        id_re2_i,
    input  logic [4:0]  id_raddr2_i,
    input  logic        id_llbit_re_i,
    input  logic        id_issue_i,
    input  logic        id_we_i,
    input  logic [4:0]  id_waddr_i,
    input  logic        id_slow_i,
    input  logic        id_llbit_we_i,
    input  logic        wb_retire_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic        wb_llbit_we_i,
    input  logic        flush_i,
    output logic        id_stall_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_q [REG_NUM];
    logic [CNT_W-1:0]   cnt_d [REG_NUM];
    logic [CNT_W-1:0]   llbit_q, llbit_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;
    logic [REG_NUM-1:0] pend;
    logic               llbit_pend;
    logic               trk, rtr, llbit_inc, llbit_dec;
    logic               stall, busy;

    // Saturating up/down counter step; coincident inc and dec cancel.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec) begin
            return (c == CntMax) ? c : c + CntOne;
        end else if (dec && !inc) begin
            return (c == '0) ? c : c - CntOne;
        end
        return c;
    endfunction

    // A pending write whose last instance retires this cycle is visible via write-through.
    always_comb begin
        pend = '0;
        rtr  = wb_retire_i && (wb_waddr_i != 5'd0);
        for (int r = 1; r < REG_NUM; r++) begin
            pend[r] = (cnt_q[r] != '0) &&
                      !((cnt_q[r] == CntOne) && rtr && (wb_waddr_i == 5'(r)));
        end
        llbit_dec  = wb_retire_i && wb_llbit_we_i;
        llbit_pend = (llbit_q != '0) && !((llbit_q == CntOne) && llbit_dec);
    end

    always_comb begin
        stall = 1'b0;
        if (id_re1_i && (id_raddr1_i != 5'd0) && pend[id_raddr1_i]) begin
            stall = 1'b1;
        end
        if (id_re2_i && (id_raddr2_i != 5'd0) && pend[id_raddr2_i]) begin
            stall = 1'b1;
        end
        if (id_llbit_re_i && llbit_pend) begin
            stall = 1'b1;
        end
        if (id_we_i && id_slow_i && (cnt_q[id_waddr_i] == CntMax)) begin
            stall = 1'b1;
        end
    end

    assign trk       = id_issue_i && !stall && id_we_i && id_slow_i && (id_waddr_i != 5'd0);
    assign llbit_inc = id_issue_i && !stall && id_llbit_we_i;

    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            cnt_d[r] = flush_i ? '0 :
                       cnt_step(cnt_q[r], trk && (id_waddr_i == 5'(r)),
                                rtr && (wb_waddr_i == 5'(r)));
        end
        llbit_d     = flush_i ? '0 : cnt_step(llbit_q, llbit_inc, llbit_dec);
        stall_cnt_d = stall_cnt_q + ((stall && !flush_i) ? 32'd1 : 32'd0);
    end

    always_comb begin
        busy = (llbit_q != '0);
        for (int r = 1; r < REG_NUM; r++) begin
            if (cnt_q[r] != '0) begin
                busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= '0;
            end
            llbit_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            llbit_q     <= llbit_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_stall_o  = stall;
    assign busy_o      = busy;
    assign stall_cnt_o = stall_cnt_q;

endmodule
